octa16_uio_arbiter: RTL and testbench
=====================================

Name: octa16_uio_arbiter

Overview:
Shares the 8-bit bidirectional uio pin bus of tt_um_octa16 between two requesters: the instruction-fetch unit and the load/store unit. Each granted 16-bit transaction is serialised into three byte phases on the bus: address, data-high, then data-low. The block drives uio_out/uio_oe and a strobe/direction pair, and returns read data to the requester. It sits between the core and the top-level pin assignments.

Parameters:
WAIT_STATES, 0, extra cycles inserted per bus phase (legal range 0..15).
DATA_FIRST, 1, fixed-priority winner when both requesters are active (1 = data unit, 0 = fetch unit). Ignored when round-robin is compiled in.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; the top level drives rst = ~rst_n
fetch_req  in  1  fetch request; held high until fetch_done
fetch_addr  in  8  fetch byte address
fetch_gnt  out  1  one-cycle pulse; fetch request accepted
fetch_done  out  1  one-cycle pulse; fetch_rdata valid
fetch_rdata  out  16  read data; held until the next fetch completes
data_req  in  1  load/store request; held high until data_done
data_we  in  1  1 = store, 0 = load
data_addr  in  8  load/store address
data_wdata  in  16  store data
data_gnt  out  1  one-cycle pulse; data request accepted
data_done  out  1  one-cycle pulse; data_rdata valid on loads
data_rdata  out  16  load data; held until the next load completes
uio_in  in  8  pin input path
uio_out  out  8  pin output path
uio_oe  out  8  pin direction (1 = output)
ext_strobe  out  1  high in the last cycle of each phase
ext_we  out  1  transaction is a write; valid whenever ext_phase != IDLE
ext_phase  out  2  00 idle, 01 addr, 10 data-high, 11 data-low
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0, uio_oe 8'h00, FSM in IDLE, rdata registers 0, round-robin pointer favouring data.
- FSM states: IDLE -> ADDR -> DHI -> DLO -> DONE -> IDLE.
- Each of ADDR, DHI and DLO lasts 1+WAIT_STATES cycles, counted by a wait counter that is cleared on phase entry.
- IDLE: if any req is high at edge N, the winner's addr/we/wdata are latched. At N+1 the FSM is in ADDR and the winner's gnt is high for exactly that cycle.
- ADDR: uio_out = latched addr, uio_oe = 8'hFF.
- DHI: on a write, uio_out = wdata[15:8] and uio_oe = 8'hFF. On a read, uio_oe = 8'h00 and rdata[15:8] is captured from uio_in in the last (strobe) cycle.
- DLO: same as DHI using byte [7:0].
- DONE: one cycle. The winner's done = 1 and the new rdata is visible at the outputs. uio_oe = 8'h00. No grant is issued in this cycle, so a requester sees done before it drops req.
- Latency with WAIT_STATES=0: req at N -> gnt at N+1 -> done at N+4. The earliest next grant is at N+6. In general, done occurs at N+4+3*WAIT_STATES.
- Only the rdata of the winning requester updates, and only on reads. Stores leave the rdata registers unchanged.
- Arbitration (fixed priority): when both reqs are high in IDLE, the DATA_FIRST side wins. The loser keeps req high and is granted after the winner's DONE.
- uio_out = 0 whenever uio_oe = 8'h00.
- Bus turnaround: during a read, uio_oe goes 8'hFF -> 8'h00 on the ADDR -> DHI edge. uio_oe is never high in DONE or IDLE.
- Reset mid-transaction: at the next edge the FSM returns to IDLE with uio_oe = 0. No done pulse is produced and partial rdata is discarded, so rdata keeps its pre-transaction value.
- req dropped before done: protocol violation. The FSM completes the transaction anyway and pulses done.
- Inputs are ignored outside the IDLE grant cycle; latched values are used for the whole transaction.

Optional Feature:
OCTA16_UIO_RR_EN
- Defined: round-robin arbitration. A 1-bit pointer flips to the non-granted requester on every grant, so under continuous contention grants alternate D, F, D, F.
- Undefined: fixed priority per DATA_FIRST, the pointer logic is absent, and a continuously asserted winner can starve the other requester.

Decomposition:
- Package octa16_uio_pkg:
  - phase encoding enum (IDLE, ADDR, DHI, DLO as 2-bit ext_phase codes)
  - FSM state typedef
  - OE_OUT = 8'hFF, OE_IN = 8'h00
  - requester-id typedef (REQ_FETCH, REQ_DATA)
- Sub-module octa16_uio_grant: winner selection (priority or round-robin) plus the round-robin pointer register. It takes both reqs and a grant-enable and returns a one-hot winner.
- The wait counter and phase FSM stay in the top.

Test Plan:
- Fetch read, WAIT=0: fetch_addr 8'h3C, bus returns 8'hA5 in DHI and 8'h5A in DLO -> gnt at N+1, uio_out=8'h3C/oe=FF in ADDR, fetch_done at N+4, fetch_rdata=16'hA55A.
- Data write, WAIT=2: addr 8'h10, wdata 16'hBEEF -> three phases of 3 cycles each, uio_out sequence 8'h10, 8'hBE, 8'hEF with oe=FF, ext_we=1, done at N+10, data_rdata unchanged.
- Simultaneous reqs, fixed priority, DATA_FIRST=1 -> data granted first, fetch granted 2 cycles after data_done. With OCTA16_UIO_RR_EN and both reqs held: gnt order D, F, D, F.
- Reset asserted in DHI of a read -> IDLE next cycle, uio_oe=00, no done pulse, rdata keeps its prior value, and a fresh request completes normally afterwards.
- Held req across done: fetch_req held high through DONE -> no grant in the DONE cycle. After req drops in DONE+1, no further gnt occurs.

Source files
------------

// File: rtl/octa16_uio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : octa16_uio_pkg
// Description : Shared types and constants for the octa16 uio bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

package octa16_uio_pkg;

  // Bus phase codes exactly as presented on ext_phase
  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_ADDR = 2'b01,
    PH_DHI  = 2'b10,
    PH_DLO  = 2'b11
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [7:0] OE_OUT = 8'hFF;
  localparam logic [7:0] OE_IN  = 8'h00;

  // Also the bit position of each requester in the one-hot winner vector
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  function automatic phase_t state_to_phase(input state_t s);
    phase_t p;
    case (s)
      ST_ADDR: p = PH_ADDR;
      ST_DHI:  p = PH_DHI;
      ST_DLO:  p = PH_DLO;
      default: p = PH_IDLE;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/octa16_uio_grant.sv
`default_nettype none
// ============================================================================
// Module      : octa16_uio_grant
// Description : Picks the winning requester; fixed priority, or round-robin
//               when OCTA16_UIO_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================

module octa16_uio_grant
  import octa16_uio_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
`ifdef OCTA16_UIO_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       grant_en,
  output logic [1:0] winner
);

  logic w_favour_data;
  logic w_pick_data;
  logic w_any_req;

`ifdef OCTA16_UIO_RR_EN
  logic r_ptr;

  // Pointer moves to whichever side did not win, so contention alternates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (grant_en && w_any_req) begin
      r_ptr <= ~w_pick_data;
    end
  end

  assign w_favour_data = r_ptr;
`else
  assign w_favour_data = DATA_FIRST;
`endif

  assign w_any_req   = fetch_req | data_req;
  assign w_pick_data = data_req & (~fetch_req | w_favour_data);

  always_comb begin
    winner = 2'b00;
    if (grant_en && w_any_req) begin
      winner[REQ_DATA]  = w_pick_data;
      winner[REQ_FETCH] = ~w_pick_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/octa16_uio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : octa16_uio_arbiter
// Description : Serialises fetch and load/store 16-bit transactions onto the
//               8-bit uio bus (addr, data-high, data-low). Round-robin
//               arbitration is compiled in with OCTA16_UIO_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module octa16_uio_arbiter
  import octa16_uio_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_done,
  output logic [15:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [7:0]  data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_gnt,
  output logic        data_done,
  output logic [15:0] data_rdata,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic        ext_strobe,
  output logic        ext_we,
  output logic [1:0]  ext_phase,
  output logic        busy
);

  localparam logic [3:0] c_wait_last = 4'(WAIT_STATES);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait;
  logic        w_phase_last;
  logic        w_grant_en;
  logic [1:0]  w_winner;
  logic        w_start;

  req_id_t     r_owner;
  logic [7:0]  r_addr;
  logic        r_we;
  logic [15:0] r_wdata;
  logic [7:0]  r_rd_hi;
  logic [15:0] r_fetch_rdata;
  logic [15:0] r_data_rdata;

  assign w_grant_en   = (r_state == ST_IDLE);
  assign w_start      = |w_winner;
  assign w_phase_last = (r_wait == c_wait_last);

  octa16_uio_grant #(
    .DATA_FIRST (DATA_FIRST)
  ) u_grant (
`ifdef OCTA16_UIO_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .fetch_req (fetch_req),
    .data_req  (data_req),
    .grant_en  (w_grant_en),
    .winner    (w_winner)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_start)      w_next_state = ST_ADDR;
      ST_ADDR: if (w_phase_last) w_next_state = ST_DHI;
      ST_DHI:  if (w_phase_last) w_next_state = ST_DLO;
      ST_DLO:  if (w_phase_last) w_next_state = ST_DONE;
      ST_DONE:                   w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state != w_next_state) begin
        r_wait <= 4'd0;
      end else if (!w_phase_last) begin
        r_wait <= r_wait + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= REQ_FETCH;
      r_addr  <= 8'h00;
      r_we    <= 1'b0;
      r_wdata <= 16'h0000;
    end else if (w_grant_en && w_start) begin
      r_owner <= w_winner[REQ_DATA] ? REQ_DATA : REQ_FETCH;
      r_addr  <= w_winner[REQ_DATA] ? data_addr : fetch_addr;
      r_we    <= w_winner[REQ_DATA] & data_we;
      r_wdata <= data_wdata;
    end
  end

  // A reset landing mid-transaction only aborts it; read data already
  // returned to a requester survives and is cleared only from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_hi <= 8'h00;
      if (r_state == ST_IDLE) begin
        r_fetch_rdata <= 16'h0000;
        r_data_rdata  <= 16'h0000;
      end
    end else begin
      if (r_state == ST_DHI && w_phase_last && !r_we) begin
        r_rd_hi <= uio_in;
      end
      if (r_state == ST_DLO && w_phase_last && !r_we) begin
        if (r_owner == REQ_FETCH) begin
          r_fetch_rdata <= {r_rd_hi, uio_in};
        end else begin
          r_data_rdata  <= {r_rd_hi, uio_in};
        end
      end
    end
  end

  always_comb begin
    uio_out    = 8'h00;
    uio_oe     = OE_IN;
    ext_strobe = 1'b0;
    ext_we     = 1'b0;
    fetch_gnt  = 1'b0;
    data_gnt   = 1'b0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    ext_phase  = state_to_phase(r_state);
    case (r_state)
      ST_ADDR: begin
        uio_out    = r_addr;
        uio_oe     = OE_OUT;
        ext_strobe = w_phase_last;
        ext_we     = r_we;
        if (r_wait == 4'd0) begin
          fetch_gnt = (r_owner == REQ_FETCH);
          data_gnt  = (r_owner == REQ_DATA);
        end
      end
      ST_DHI: begin
        ext_strobe = w_phase_last;
        ext_we     = r_we;
        if (r_we) begin
          uio_out = r_wdata[15:8];
          uio_oe  = OE_OUT;
        end
      end
      ST_DLO: begin
        ext_strobe = w_phase_last;
        ext_we     = r_we;
        if (r_we) begin
          uio_out = r_wdata[7:0];
          uio_oe  = OE_OUT;
        end
      end
      ST_DONE: begin
        fetch_done = (r_owner == REQ_FETCH);
        data_done  = (r_owner == REQ_DATA);
      end
      default: ;
    endcase
  end

  assign fetch_rdata = r_fetch_rdata;
  assign data_rdata  = r_data_rdata;
  assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_octa16_uio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_octa16_uio_arbiter
// Description : Directed self-checking bench; one instance with no wait
//               states and one with two wait states per phase.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_octa16_uio_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance with WAIT_STATES = 0
  logic        fetch_req, fetch_gnt, fetch_done;
  logic [7:0]  fetch_addr;
  logic [15:0] fetch_rdata;
  logic        data_req, data_we, data_gnt, data_done;
  logic [7:0]  data_addr;
  logic [15:0] data_wdata, data_rdata;
  logic [7:0]  uio_in, uio_out, uio_oe;
  logic        ext_strobe, ext_we, busy;
  logic [1:0]  ext_phase;

  // Instance with WAIT_STATES = 2
  logic        b_fetch_req, b_fetch_gnt, b_fetch_done;
  logic [7:0]  b_fetch_addr;
  logic [15:0] b_fetch_rdata;
  logic        b_data_req, b_data_we, b_data_gnt, b_data_done;
  logic [7:0]  b_data_addr;
  logic [15:0] b_data_wdata, b_data_rdata;
  logic [7:0]  b_uio_in, b_uio_out, b_uio_oe;
  logic        b_ext_strobe, b_ext_we, b_busy;
  logic [1:0]  b_ext_phase;

  octa16_uio_arbiter #(.WAIT_STATES(0), .DATA_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
    .data_rdata(data_rdata),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
    .ext_strobe(ext_strobe), .ext_we(ext_we), .ext_phase(ext_phase), .busy(busy)
  );

  octa16_uio_arbiter #(.WAIT_STATES(2), .DATA_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst),
    .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_gnt(b_fetch_gnt),
    .fetch_done(b_fetch_done), .fetch_rdata(b_fetch_rdata),
    .data_req(b_data_req), .data_we(b_data_we), .data_addr(b_data_addr),
    .data_wdata(b_data_wdata), .data_gnt(b_data_gnt), .data_done(b_data_done),
    .data_rdata(b_data_rdata),
    .uio_in(b_uio_in), .uio_out(b_uio_out), .uio_oe(b_uio_oe),
    .ext_strobe(b_ext_strobe), .ext_we(b_ext_we), .ext_phase(b_ext_phase), .busy(b_busy)
  );

  task automatic do_reset();
    fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0; data_addr = 0;
    data_wdata = 0; uio_in = 0;
    b_fetch_req = 0; b_fetch_addr = 0; b_data_req = 0; b_data_we = 0;
    b_data_addr = 0; b_data_wdata = 0; b_uio_in = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one WAIT_STATES=0 fetch read on u_dut0; ok reports gnt and done seen.
  task automatic drive_fetch_read(input logic [7:0] addr, input logic [7:0] hi,
                                  input logic [7:0] lo, output bit ok);
    bit got_gnt = 0;
    bit got_done = 0;
    fetch_addr = addr; fetch_req = 1'b1;
    for (int i = 0; i < 10 && !got_gnt; i++) begin
      @(negedge clk);
      got_gnt = fetch_gnt;
    end
    uio_in = hi;
    @(negedge clk);
    @(negedge clk);
    uio_in = lo;
    for (int i = 0; i < 10 && !got_done; i++) begin
      @(negedge clk);
      got_done = fetch_done;
    end
    fetch_req = 1'b0;
    ok = got_gnt && got_done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    n_checks++;
    if ({fetch_gnt, fetch_done, data_gnt, data_done, uio_out, uio_oe, ext_strobe,
         ext_we, ext_phase, busy, fetch_rdata, data_rdata} !== 57'd0) begin
      n_fail++;
      $display("FAIL reset_dut0: got gnt/done %b%b%b%b out %h oe %h phase %b busy %b rd %h/%h want all zero",
               fetch_gnt, fetch_done, data_gnt, data_done, uio_out, uio_oe, ext_phase, busy,
               fetch_rdata, data_rdata);
    end
    n_checks++;
    if ({b_fetch_gnt, b_data_gnt, b_uio_out, b_uio_oe, b_ext_phase, b_busy,
         b_data_rdata} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_dut2: got out %h oe %h phase %b busy %b rd %h want all zero",
               b_uio_out, b_uio_oe, b_ext_phase, b_busy, b_data_rdata);
    end
  endtask

  task automatic test_fetch_read();
    do_reset();
    fetch_addr = 8'h3C; fetch_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, data_gnt, ext_phase, uio_oe, uio_out, ext_strobe, ext_we, busy}
        !== {1'b1, 1'b0, 2'b01, 8'hFF, 8'h3C, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_addr_phase: got gnt %b phase %b oe %h out %h strobe %b we %b want 1 01 ff 3c 1 0",
               fetch_gnt, ext_phase, uio_oe, uio_out, ext_strobe, ext_we);
    end
    uio_in = 8'hA5;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, ext_phase, uio_oe, uio_out, ext_strobe}
        !== {1'b0, 2'b10, 8'h00, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_dhi_phase: got gnt %b phase %b oe %h out %h strobe %b want 0 10 00 00 1",
               fetch_gnt, ext_phase, uio_oe, uio_out, ext_strobe);
    end
    @(negedge clk);
    uio_in = 8'h5A;
    n_checks++;
    if ({ext_phase, uio_oe, uio_out, fetch_done, fetch_rdata}
        !== {2'b11, 8'h00, 8'h00, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL fetch_dlo_phase: got phase %b oe %h out %h done %b rd %h want 11 00 00 0 0000",
               ext_phase, uio_oe, uio_out, fetch_done, fetch_rdata);
    end
    @(negedge clk);
    n_checks++;
    if ({fetch_done, data_done, fetch_gnt, ext_phase, uio_oe, busy, fetch_rdata, data_rdata}
        !== {1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 16'hA55A, 16'h0000}) begin
      n_fail++;
      $display("FAIL fetch_done_cycle: got done %b/%b gnt %b phase %b oe %h busy %b rd %h/%h want 1/0 0 00 00 1 a55a/0000",
               fetch_done, data_done, fetch_gnt, ext_phase, uio_oe, busy, fetch_rdata, data_rdata);
    end
    fetch_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({fetch_done, busy, fetch_rdata} !== {1'b0, 1'b0, 16'hA55A}) begin
      n_fail++;
      $display("FAIL fetch_after_done: got done %b busy %b rd %h want 0 0 a55a",
               fetch_done, busy, fetch_rdata);
    end
  endtask

  task automatic test_data_write_wait2();
    logic [1:0] exp_phase;
    logic [7:0] exp_out;
    do_reset();
    // Preload data_rdata with a load so the store can be seen to leave it alone
    b_data_req = 1'b1; b_data_we = 1'b0; b_data_addr = 8'h55; b_uio_in = 8'h12;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 7) b_uio_in = 8'h34;
      if (k == 10) begin
        n_checks++;
        if ({b_data_done, b_data_rdata} !== {1'b1, 16'h1234}) begin
          n_fail++;
          $display("FAIL w2_load_done: got done %b rd %h want 1 1234", b_data_done, b_data_rdata);
        end
        b_data_req = 1'b0;
      end
    end
    @(negedge clk);
    b_data_req = 1'b1; b_data_we = 1'b1; b_data_addr = 8'h10; b_data_wdata = 16'hBEEF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin
        b_data_addr = 8'h77; b_data_wdata = 16'h0000; b_data_we = 1'b0;
      end
      if (k <= 9) begin
        exp_phase = 2'(1 + (k - 1) / 3);
        exp_out   = (k <= 3) ? 8'h10 : (k <= 6) ? 8'hBE : 8'hEF;
        n_checks++;
        if ({b_data_gnt, b_ext_phase, b_uio_oe, b_uio_out, b_ext_strobe, b_ext_we, b_data_done}
            !== {(k == 1), exp_phase, 8'hFF, exp_out, ((k - 1) % 3 == 2), 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL w2_store_cycle%0d: got gnt %b phase %b oe %h out %h strobe %b we %b done %b want %b %b ff %h %b 1 0",
                   k, b_data_gnt, b_ext_phase, b_uio_oe, b_uio_out, b_ext_strobe, b_ext_we,
                   b_data_done, (k == 1), exp_phase, exp_out, ((k - 1) % 3 == 2));
        end
      end else begin
        n_checks++;
        if ({b_data_done, b_ext_phase, b_uio_oe, b_uio_out, b_data_rdata}
            !== {1'b1, 2'b00, 8'h00, 8'h00, 16'h1234}) begin
          n_fail++;
          $display("FAIL w2_store_done: got done %b phase %b oe %h out %h rd %h want 1 00 00 00 1234",
                   b_data_done, b_ext_phase, b_uio_oe, b_uio_out, b_data_rdata);
        end
        b_data_req = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_v;
    do_reset();
    fetch_addr = 8'h40; data_addr = 8'h20; data_we = 1'b0; uio_in = 8'hC3;
    fetch_req = 1'b1; data_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_v = {(k == 1), (k == 6), (k == 4), (k == 9)};
      n_checks++;
      if ({data_gnt, fetch_gnt, data_done, fetch_done} !== exp_v) begin
        n_fail++;
        $display("FAIL simul_cycle%0d: got dgnt/fgnt/ddone/fdone %b%b%b%b want %b",
                 k, data_gnt, fetch_gnt, data_done, fetch_done, exp_v);
      end
      if (k == 4) begin
        n_checks++;
        if ({data_rdata, fetch_rdata} !== {16'hC3C3, 16'h0000}) begin
          n_fail++;
          $display("FAIL simul_data_rd: got data %h fetch %h want c3c3 0000", data_rdata, fetch_rdata);
        end
        data_req = 1'b0;
      end
      if (k == 6) begin
        n_checks++;
        if ({uio_out, uio_oe} !== {8'h40, 8'hFF}) begin
          n_fail++;
          $display("FAIL simul_fetch_addr: got out %h oe %h want 40 ff", uio_out, uio_oe);
        end
      end
      if (k == 9) begin
        n_checks++;
        if (fetch_rdata !== 16'hC3C3) begin
          n_fail++;
          $display("FAIL simul_fetch_rd: got %h want c3c3", fetch_rdata);
        end
        fetch_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    do_reset();
    fetch_addr = 8'h01; data_addr = 8'h02; data_we = 1'b1; data_wdata = 16'h1111;
    fetch_req = 1'b1; data_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_g = 2'b00;
      if (k % 5 == 1) begin
`ifdef OCTA16_UIO_RR_EN
        exp_g = (((k - 1) / 5) % 2 == 0) ? 2'b10 : 2'b01;
`else
        exp_g = 2'b10;
`endif
      end
      n_checks++;
      if ({data_gnt, fetch_gnt} !== exp_g) begin
        n_fail++;
        $display("FAIL contention_cycle%0d: got dgnt/fgnt %b%b want %b", k, data_gnt, fetch_gnt, exp_g);
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    drive_fetch_read(8'h3C, 8'h13, 8'h57, ok);
    n_checks++;
    if (!ok || fetch_rdata !== 16'h1357) begin
      n_fail++;
      $display("FAIL rstmid_preload: got ok %0d rd %h want 1 1357", ok, fetch_rdata);
    end
    @(negedge clk);
    fetch_addr = 8'h66; fetch_req = 1'b1; uio_in = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ext_phase !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_in_dhi: got phase %b want 10", ext_phase);
    end
    rst = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ext_phase, uio_oe, busy, fetch_done, fetch_rdata}
        !== {2'b00, 8'h00, 1'b0, 1'b0, 16'h1357}) begin
      n_fail++;
      $display("FAIL rstmid_abort: got phase %b oe %h busy %b done %b rd %h want 00 00 0 0 1357",
               ext_phase, uio_oe, busy, fetch_done, fetch_rdata);
    end
    @(negedge clk);
    n_checks++;
    if ({fetch_done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got done %b busy %b want 0 0", fetch_done, busy);
    end
    drive_fetch_read(8'h44, 8'h9A, 8'hBC, ok);
    n_checks++;
    if (!ok || fetch_rdata !== 16'h9ABC) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got ok %0d rd %h want 1 9abc", ok, fetch_rdata);
    end
  endtask

  task automatic test_held_req();
    do_reset();
    fetch_addr = 8'h08; fetch_req = 1'b1; uio_in = 8'h00;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({fetch_done, fetch_gnt, data_gnt} !== 3'b100) begin
      n_fail++;
      $display("FAIL held_done_cycle: got done %b fgnt %b dgnt %b want 1 0 0",
               fetch_done, fetch_gnt, data_gnt);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      n_checks++;
      if ({fetch_gnt, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL held_no_regrant%0d: got gnt %b busy %b want 0 0", k, fetch_gnt, busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    test_reset();
    test_fetch_read();
    test_data_write_wait2();
    test_simultaneous();
    test_contention();
    test_reset_mid();
    test_held_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
